// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory controller between fetch (F) and data (D) ports.
// One transaction in flight; optional mem_ready timeout enabled by `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_grant, w_grant_nxt;
    logic                r_mem_valid, w_mem_valid_nxt;
    logic                r_mem_rw, w_mem_rw_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_f_rdata, w_f_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_f_done, w_f_done_nxt;
    logic                r_d_done, w_d_done_nxt;
    logic                r_err, w_err_nxt;
    logic                w_pick;
    logic                w_timeout;

    // 0 = F, 1 = D; on a tie the port that did not win last time goes first.
    assign w_pick = (f_req && d_req) ? ~r_last_grant : d_req;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != BUSY) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
    end

    assign w_timeout = (r_state == BUSY) && (r_cnt == CW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_mem_valid_nxt  = r_mem_valid;
        w_mem_rw_nxt     = r_mem_rw;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_f_rdata_nxt    = r_f_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_f_done_nxt     = 1'b0;
        w_d_done_nxt     = 1'b0;
        w_err_nxt        = r_err;
        case (r_state)
            IDLE: begin
                if (f_req || d_req) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_mem_valid_nxt  = 1'b1;
                    w_state_nxt      = BUSY;
                    if (w_pick) begin
                        w_mem_rw_nxt    = d_rw;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end else begin
                        w_mem_rw_nxt   = 1'b1;
                        w_mem_addr_nxt = f_addr;
                    end
                end
            end
            BUSY: begin
                // A ready arriving on the timeout edge is a normal completion.
                if (mem_ready || w_timeout) begin
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = DONE;
                    if (r_grant) begin
                        w_d_done_nxt  = 1'b1;
                        w_d_rdata_nxt = mem_ready ? mem_rdata : '1;
                    end else begin
                        w_f_done_nxt  = 1'b1;
                        w_f_rdata_nxt = mem_ready ? mem_rdata : '1;
                    end
                    if (!mem_ready) w_err_nxt = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_rw     <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
            r_f_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_mem_rw     <= w_mem_rw_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_f_rdata    <= w_f_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_f_done     <= w_f_done_nxt;
            r_d_done     <= w_d_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign f_rdata   = r_f_rdata;
    assign f_done    = r_f_done;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign mem_valid = r_mem_valid;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs checked 1ns after each rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [7:0]  f_addr;
    logic [31:0] f_rdata;
    logic        f_done;
    logic        d_req;
    logic        d_rw;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_valid;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        grant;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_rw = 1; d_addr = 0;
        d_wdata = 0; mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_rw",    {31'd0, mem_rw},    32'd1);
        chk("rst_addr",  {24'd0, mem_addr},  32'd0);
        chk("rst_wdata", mem_wdata,          32'd0);
        chk("rst_done",  {30'd0, f_done, d_done}, 32'd0);
        chk("rst_rdata", f_rdata | d_rdata,  32'd0);
        chk("rst_grant", {31'd0, grant},     32'd0);
        chk("rst_err",   {31'd0, err},       32'd0);
        reset = 1'b0;

        // Ready in IDLE is ignored.
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("idle_rdy_done",  {30'd0, f_done, d_done}, 32'd0);
        chk("idle_rdy_valid", {31'd0, mem_valid},      32'd0);
        mem_ready = 0;

        // Fetch read.
        f_req = 1; f_addr = 8'hFA;
        tick();
        chk("f_valid", {31'd0, mem_valid}, 32'd1);
        chk("f_rw",    {31'd0, mem_rw},    32'd1);
        chk("f_addr",  {24'd0, mem_addr},  32'h0000_00FA);
        chk("f_grant", {31'd0, grant},     32'd0);
        tick(); tick();
        chk("f_wait_done", {30'd0, f_done, d_done}, 32'd0);
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        chk("f_done",     {31'd0, f_done},    32'd1);
        chk("f_d_done",   {31'd0, d_done},    32'd0);
        chk("f_rdata",    f_rdata,            32'h1234_5678);
        chk("f_valid_lo", {31'd0, mem_valid}, 32'd0);
        mem_ready = 0; f_req = 0;
        tick();
        chk("f_done_1cyc", {31'd0, f_done}, 32'd0);
        chk("f_rdata_hold", f_rdata, 32'h1234_5678);

        // Data write.
        d_req = 1; d_rw = 0; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("w_grant", {31'd0, grant},    32'd1);
        chk("w_rw",    {31'd0, mem_rw},   32'd0);
        chk("w_addr",  {24'd0, mem_addr}, 32'h0000_0010);
        chk("w_wdata", mem_wdata,         32'hDEAD_BEEF);
        d_wdata = 32'h0;
        tick();
        chk("w_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        chk("w_done",   {30'd0, f_done, d_done}, 32'd1);
        chk("w_rdata",  d_rdata, 32'hA5A5_A5A5);
        mem_ready = 0; d_req = 0;
        tick();
        chk("w_done_1cyc", {31'd0, d_done}, 32'd0);

        // Contention: both held high; expect F, D, F, D. Also D inputs toggle while F is busy.
        f_req = 1; d_req = 1; d_rw = 1; f_addr = 8'h20; d_addr = 8'h30;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_grant", {31'd0, grant}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("c_addr",  {24'd0, mem_addr}, (i % 2 == 1) ? 32'h30 : 32'h20);
            if (i % 2 == 0) begin
                d_addr = 8'h77; d_rw = 0;
                tick();
                chk("c_stable_addr", {24'd0, mem_addr}, 32'h20);
                chk("c_stable_rw",   {31'd0, mem_rw},   32'd1);
                d_addr = 8'h30; d_rw = 1;
            end
            mem_ready = 1; mem_rdata = 32'h100 + i;
            tick();
            chk("c_done", {30'd0, f_done, d_done}, (i % 2 == 1) ? 32'd1 : 32'd2);
            chk("c_rdata", (i % 2 == 1) ? d_rdata : f_rdata, 32'h100 + i);
            mem_ready = 0;
            if (i == 3) begin f_req = 0; d_req = 0; end
            tick();
        end
        chk("c_f_hold", f_rdata, 32'h102);

        // Reset mid-transaction: F in flight, so without reset D would win the next tie.
        f_req = 1; f_addr = 8'h40;
        tick();
        chk("r_valid", {31'd0, mem_valid}, 32'd1);
        reset = 1; f_req = 0; mem_ready = 1; mem_rdata = 32'hCAFE_0000;
        tick();
        chk("r_valid_lo", {31'd0, mem_valid}, 32'd0);
        chk("r_no_done",  {30'd0, f_done, d_done}, 32'd0);
        reset = 0; mem_ready = 0;
        tick();
        chk("r_no_done2", {30'd0, f_done, d_done}, 32'd0);
        f_req = 1; d_req = 1; f_addr = 8'h21; d_addr = 8'h31;
        tick();
        chk("r_tie_grant", {31'd0, grant},    32'd0);
        chk("r_tie_addr",  {24'd0, mem_addr}, 32'h21);
        mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        chk("r_done", {30'd0, f_done, d_done}, 32'd2);
        mem_ready = 0; f_req = 0; d_req = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        d_req = 1; d_rw = 1; d_addr = 8'h50;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t_no_done_yet", {31'd0, d_done}, 32'd0);
        chk("t_err_lo",      {31'd0, err},    32'd0);
        tick();
        chk("t_done",  {31'd0, d_done}, 32'd1);
        chk("t_rdata", d_rdata,         32'hFFFF_FFFF);
        chk("t_err",   {31'd0, err},    32'd1);
        d_req = 0;
        tick();
        f_req = 1; f_addr = 8'h60;
        tick();
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("t2_done",  {31'd0, f_done}, 32'd1);
        chk("t2_rdata", f_rdata,         32'h0BAD_F00D);
        chk("t2_err",   {31'd0, err},    32'd1);
        mem_ready = 0; f_req = 0;
        tick();
`else
        d_req = 1; d_rw = 1; d_addr = 8'h50;
        for (int i = 0; i < 20; i++) tick();
        chk("nt_wait_done", {31'd0, d_done},    32'd0);
        chk("nt_valid",     {31'd0, mem_valid}, 32'd1);
        chk("nt_err",       {31'd0, err},       32'd0);
        mem_ready = 1; mem_rdata = 32'h7777_0001;
        tick();
        chk("nt_done", {31'd0, d_done}, 32'd1);
        mem_ready = 0; d_req = 0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single memory controller and RAM path between the instruction-fetch port (F) and the load/store data port (D) of the control unit.
- Holds one transaction in flight at a time and drives the controller's Valid/RW/Addr/write-data handshake.
- Waits for the controller's ready, then returns read data and a done pulse to the winning requester.
- Sits between the control unit and the memory controller; the controller and RAM are unchanged.

Parameters:
- ADDR_W, 8, address width of both requesters and of the controller port.
- DATA_W, 32, data width.
- TIMEOUT, 16, cycles to wait for mem_ready before aborting; used only with the optional feature.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
f_req  in  1  fetch request; held high until f_done.
f_addr  in  ADDR_W  fetch address; always a read.
f_rdata  out  DATA_W  fetch read data; valid while f_done=1.
f_done  out  1  one-cycle completion pulse.
d_req  in  1  data request; held high until d_done.
d_rw  in  1  1=read, 0=write; same encoding as the controller's RW.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  write data.
d_rdata  out  DATA_W  data read data; valid while d_done=1.
d_done  out  1  one-cycle completion pulse.
mem_valid  out  1  request to the memory controller (Valid).
mem_rw  out  1  to the controller's RW.
mem_addr  out  ADDR_W  to the controller's Addr_in.
mem_wdata  out  DATA_W  write data to the controller.
mem_rdata  in  DATA_W  read data from the controller.
mem_ready  in  1  controller completion strobe.
grant  out  1  0=F owns the bus, 1=D owns it; meaningful while busy.
err  out  1  timeout flag; sticky until reset. Tied 0 when the optional feature is compiled out.

Behaviour:
- All outputs are registered.
- Reset values: mem_valid=0, mem_rw=1, mem_addr=0, mem_wdata=0, f_done=0, d_done=0, f_rdata=0, d_rdata=0, grant=0, err=0, state=IDLE, last_grant=D.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one of f_req/d_req high: grant it.
  - Both high: grant the requester that is not last_grant (round-robin). After reset, F wins the first tie.
  - On grant, capture addr, rw and wdata into the mem_* registers. F forces mem_rw=1.
  - Set mem_valid=1, update grant and last_grant, go to BUSY. mem_valid is high in the cycle after the edge that sampled the request.
- BUSY:
  - mem_valid, mem_rw, mem_addr and mem_wdata stay stable.
  - Requester inputs are ignored; changes to them mid-transaction have no effect.
  - On an edge with mem_ready=1: clear mem_valid, latch mem_rdata into the granted port's rdata register (for writes as well), pulse that port's done for exactly one cycle, go to DONE.
- DONE:
  - Single turnaround cycle. done is high in this cycle and the requester drops or renews its req.
  - Always return to IDLE. No arbitration in DONE.
  - Minimum spacing between issues is 3 cycles plus the controller latency.
- rdata registers hold their value until the next completion on that port.
- mem_ready while in IDLE or DONE is ignored.
- A requester that keeps req high after done is treated as a new request in IDLE. Under contention it loses to the other port, so there is no starvation.
- Reset mid-transaction: next edge forces IDLE and mem_valid=0. No done pulse is issued; the in-flight transaction is abandoned and requesters must re-request. The next tie goes to F.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering BUSY and increments each cycle in BUSY.
  - If it reaches TIMEOUT-1 without mem_ready: clear mem_valid, pulse the granted port's done, load that port's rdata with all-ones, set err=1 (sticky until reset), go to DONE.
  - mem_ready on the same edge as the timeout wins: normal completion, err unchanged.
- Not defined: no counter exists, BUSY waits indefinitely, err is tied 0.

Test Plan:
- Fetch read: reset, f_req=1, f_addr=8'hFA, controller returns 32'h1234_5678 three cycles later -> mem_valid=1 with mem_rw=1, mem_addr=8'hFA; f_done pulses one cycle with f_rdata=32'h1234_5678; d_done stays 0.
- Data write: d_req=1, d_rw=0, d_addr=8'h10, d_wdata=32'hDEAD_BEEF -> mem_rw=0, mem_wdata=32'hDEAD_BEEF held until mem_ready; d_done pulses once.
- Contention: f_req and d_req held high continuously for 4 transactions -> grant order F, D, F, D; each done pulse goes to the matching port.
- Stability: toggle d_addr while F is BUSY -> mem_addr unchanged until F completes.
- Reset mid-op: assert reset while in BUSY -> mem_valid=0 after the next edge; no done pulse; a subsequent simultaneous request grants F.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=16): never assert mem_ready after a d read -> d_done after 16 BUSY cycles with d_rdata=32'hFFFF_FFFF, err=1 and sticky; a later normal transaction completes with err still 1.
